// File: rtl/ring_counter.sv
// Parallel-loadable ring counter: each rising edge either loads I or rotates Y by one place.
// Reset is asynchronous and active-low; Y comes straight from the register.
module ring_counter #(
  parameter int unsigned      WIDTH        = 4,
  parameter logic [WIDTH-1:0] RESET_VALUE  = {{(WIDTH-1){1'b0}}, 1'b1},
  parameter bit               ROTATE_RIGHT = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             select,
  input  logic [WIDTH-1:0] I,
  output logic [WIDTH-1:0] Y
);

  logic [WIDTH-1:0] r_y;
  logic [WIDTH-1:0] w_rot;

  generate
    if (ROTATE_RIGHT) begin : g_rot_right
      assign w_rot = {r_y[0], r_y[WIDTH-1:1]};
    end else begin : g_rot_left
      assign w_rot = {r_y[WIDTH-2:0], r_y[WIDTH-1]};
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_y <= RESET_VALUE;
    end else if (select) begin
      r_y <= w_rot;
    end else begin
      r_y <= I;
    end
  end

  assign Y = r_y;

endmodule

// File: tb/tb_ring_counter.sv
// Scoreboard bench for ring_counter: a right- and a left-rotating instance share all inputs;
// the driver queues hand-computed results, a monitor pops and compares them when they fall due.
module tb_ring_counter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       select = 1'b0;
  logic [3:0] I = 4'b0000;
  logic [3:0] y_r;
  logic [3:0] y_l;

  int unsigned cyc = 0;
  int unsigned n_chk = 0;
  int unsigned n_pass = 0;

  typedef struct {
    int unsigned due;
    logic [3:0]  er;
    logic [3:0]  el;
    string       name;
  } exp_t;

  exp_t q[$];

  ring_counter #(.WIDTH(4), .RESET_VALUE(4'b0001), .ROTATE_RIGHT(1'b1)) dut_r (
    .clk(clk), .reset(reset), .select(select), .I(I), .Y(y_r)
  );

  ring_counter #(.WIDTH(4), .RESET_VALUE(4'b0001), .ROTATE_RIGHT(1'b0)) dut_l (
    .clk(clk), .reset(reset), .select(select), .I(I), .Y(y_l)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [3:0] act, input logic [3:0] exp_v);
    n_chk++;
    if (act === exp_v) n_pass++;
    else $display("FAIL %s: got %b, expected %b (t=%0t)", nm, act, exp_v, $time);
  endtask

  // Monitor: results become due after a rising edge (checked at the next falling edge)
  // or immediately on an asynchronous reset assertion.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk or negedge reset);
      #1;
      while (q.size() > 0 && q[0].due <= cyc) begin
        e = q.pop_front();
        check({e.name, "_R"}, y_r, e.er);
        check({e.name, "_L"}, y_l, e.el);
      end
    end
  end

  // Drive inputs at the falling edge; the result is due after the next rising edge.
  task automatic step(input logic rst, input logic sel, input logic [3:0] d,
                      input logic [3:0] er, input logic [3:0] el, input string nm);
    @(negedge clk);
    reset  = rst;
    select = sel;
    I      = d;
    q.push_back('{due: cyc + 1, er: er, el: el, name: nm});
  endtask

  task automatic async_rst(input string nm);
    @(negedge clk);
    #2;
    reset = 1'b0;
    q.push_back('{due: cyc, er: 4'b0001, el: 4'b0001, name: nm});
  endtask

  initial begin
    // Reset asserted away from any edge with rotate selected and I all ones.
    select = 1'b1;
    I      = 4'b1111;
    #2;
    reset = 1'b0;
    q.push_back('{due: cyc, er: 4'b0001, el: 4'b0001, name: "rst_immediate"});
    step(1'b0, 1'b1, 4'b1111, 4'b0001, 4'b0001, "rst_hold1");
    step(1'b0, 1'b1, 4'b1111, 4'b0001, 4'b0001, "rst_hold2");
    step(1'b0, 1'b1, 4'b1111, 4'b0001, 4'b0001, "rst_hold3");

    // Release with load of 1000, then four rotations.
    step(1'b1, 1'b0, 4'b1000, 4'b1000, 4'b1000, "load_1000");
    step(1'b1, 1'b1, 4'b0000, 4'b0100, 4'b0001, "rot1");
    step(1'b1, 1'b1, 4'b0000, 4'b0010, 4'b0010, "rot2");
    step(1'b1, 1'b1, 4'b0000, 4'b0001, 4'b0100, "rot3");
    step(1'b1, 1'b1, 4'b0000, 4'b1000, 4'b1000, "rot4_period");

    // Load 0001, four rotations back to start.
    step(1'b1, 1'b0, 4'b0001, 4'b0001, 4'b0001, "load_0001");
    step(1'b1, 1'b1, 4'b1111, 4'b1000, 4'b0010, "rotb1");
    step(1'b1, 1'b1, 4'b1111, 4'b0100, 4'b0100, "rotb2");
    step(1'b1, 1'b1, 4'b1111, 4'b0010, 4'b1000, "rotb3");
    step(1'b1, 1'b1, 4'b1111, 4'b0001, 4'b0001, "rotb4_period");

    // Multi-bit pattern.
    step(1'b1, 1'b0, 4'b1010, 4'b1010, 4'b1010, "load_1010");
    step(1'b1, 1'b1, 4'b0000, 4'b0101, 4'b0101, "rot_1010_a");
    step(1'b1, 1'b1, 4'b0000, 4'b1010, 4'b1010, "rot_1010_b");

    // All zeros and all ones are fixed points of rotation.
    step(1'b1, 1'b0, 4'b0000, 4'b0000, 4'b0000, "load_0000");
    step(1'b1, 1'b1, 4'b1111, 4'b0000, 4'b0000, "rot_0000_a");
    step(1'b1, 1'b1, 4'b1111, 4'b0000, 4'b0000, "rot_0000_b");
    step(1'b1, 1'b0, 4'b1111, 4'b1111, 4'b1111, "load_1111");
    step(1'b1, 1'b1, 4'b0000, 4'b1111, 4'b1111, "rot_1111");

    // Mid-rotation reset at Y=0010 on both instances.
    step(1'b1, 1'b0, 4'b1000, 4'b1000, 4'b1000, "load_1000b");
    step(1'b1, 1'b1, 4'b0000, 4'b0100, 4'b0001, "rotc1");
    step(1'b1, 1'b1, 4'b0000, 4'b0010, 4'b0010, "rotc2");
    async_rst("mid_rst_immediate");
    step(1'b1, 1'b1, 4'b0000, 4'b1000, 4'b0010, "release_rotate");

    // Load tracks I one edge later with no rotation.
    step(1'b1, 1'b0, 4'b0011, 4'b0011, 4'b0011, "track_0011");
    step(1'b1, 1'b0, 4'b0110, 4'b0110, 4'b0110, "track_0110");
    step(1'b1, 1'b0, 4'b1001, 4'b1001, 4'b1001, "track_1001");

    // Alternating load and rotate.
    step(1'b1, 1'b1, 4'b1111, 4'b1100, 4'b0011, "alt_rot1");
    step(1'b1, 1'b0, 4'b0110, 4'b0110, 4'b0110, "alt_load");
    step(1'b1, 1'b1, 4'b0000, 4'b0011, 4'b1100, "alt_rot2");

    repeat (3) @(negedge clk);
    #2;
    n_chk++;
    if (q.size() == 0) n_pass++;
    else $display("FAIL drain: %0d expectations left, expected 0", q.size());

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #5000;
    $display("FAIL timeout: simulation still running at %0t, expected finish", $time);
    $fatal(1);
  end

endmodule
